// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: length table, pad NOP, packer FSM states
// and a saturating-add helper for the optional statistics counters.
package instr_pkg;

   localparam int n_instr_len   = 3;
   localparam int max_instr_len = 4;
   localparam int IDX_LEN       = $clog2(n_instr_len);
   localparam int LEN_W         = $clog2(max_instr_len + 1);

   localparam logic [LEN_W-1:0] instr_len [0:n_instr_len-1] = '{3'd1, 3'd2, 3'd4};

   // Length code (top IDX_LEN bits) is 0, so the pad decodes as a 1-word NOP.
   localparam logic [31:0] PAD_WORD = 32'h3C00_0000;

   typedef enum logic [1:0] {PACK, FLUSH, DONE} packer_state_t;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? '1 : s[31:0];
   endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Source-side and FIFO-side handshake bundle of the instruction packer.
// slave = packer, master = the loader/FIFO environment around it.
interface instr_packer_if #(
   parameter int WORD_LEN = 32,
   parameter int W        = 16,
   parameter int M        = instr_pkg::max_instr_len
);
   logic [0:M-1][0:WORD_LEN-1] instr_in;
   logic                       src_2_packer_vld;
   logic                       packer_2_src_rdy;
   logic                       flush;
   logic                       flush_done;
   logic [0:W-1][0:WORD_LEN-1] line_out;
   logic                       packer_2_fifo_vld;
   logic                       fifo_2_packer_rdy;
   logic                       len_err;

   modport master (
      output instr_in, src_2_packer_vld, flush, fifo_2_packer_rdy,
      input  packer_2_src_rdy, flush_done, line_out, packer_2_fifo_vld, len_err
   );

   modport slave (
      input  instr_in, src_2_packer_vld, flush, fifo_2_packer_rdy,
      output packer_2_src_rdy, flush_done, line_out, packer_2_fifo_vld, len_err
   );
endinterface

// File: rtl/instr_len_decd.sv
// Instruction length decode from the leading length code; unknown codes fall
// back to a 1-word length and raise len_ill.
module instr_len_decd
   import instr_pkg::*;
(
   input  logic [0:IDX_LEN-1] len_code,
   output logic [LEN_W-1:0]   len,
   output logic               len_ill
);
   always_comb begin
      len     = LEN_W'(1);
      len_ill = 1'b1;
      for (int i = 0; i < n_instr_len; i++) begin
         if (len_code == IDX_LEN'(i)) begin
            len     = instr_len[i];
            len_ill = 1'b0;
         end
      end
   end
endmodule

// File: rtl/instr_packer_merge.sv
// Accumulator next-value: optional pop of one line (left shift, zero fill),
// then placement of len new words starting at pos.
module instr_packer_merge
   import instr_pkg::*;
#(
   parameter int WORD_LEN = 32,
   parameter int W        = 16,
   parameter int M        = 4,
   parameter int T        = W + M,
   parameter int FW       = $clog2(T) + 1
) (
   input  logic [0:T-1][0:WORD_LEN-1] acc,
   input  logic                       pop,
   input  logic                       wr_en,
   input  logic [FW-1:0]              pos,
   input  logic [LEN_W-1:0]           len,
   input  logic [0:M-1][0:WORD_LEN-1] words,
   output logic [0:T-1][0:WORD_LEN-1] acc_nxt
);
   always_comb begin
      // Word 0 sits in the MSBs, so a left shift retires the oldest line.
      acc_nxt = pop ? (acc << (W * WORD_LEN)) : acc;
      if (wr_en) begin
         for (int j = 0; j < M; j++) begin
            if (j < int'(len) && int'(pos) + j < T)
               acc_nxt[int'(pos) + j] = words[j];
         end
      end
   end
endmodule

// File: rtl/instr_packer.sv
// Packs variable-length instructions back-to-back into fixed-width FIFO lines;
// flush pads the last partial line. INSTR_PACKER_STATS_EN adds usage counters.
module instr_packer
   import instr_pkg::*;
#(
   parameter int WORD_LEN         = 32,
   parameter int INSTR_FIFO_WIDTH = 16,
   parameter int MAX_INSTR_LEN    = max_instr_len
) (
   input logic           clk,
   input logic           rst,
   instr_packer_if.slave bus
`ifdef INSTR_PACKER_STATS_EN
   ,
   output logic [31:0]   n_instr,
   output logic [31:0]   n_lines,
   output logic [31:0]   n_pad_words
`endif
);
   localparam int W  = INSTR_FIFO_WIDTH;
   localparam int M  = MAX_INSTR_LEN;
   localparam int T  = W + M;
   localparam int FW = $clog2(T) + 1;

   logic [0:T-1][0:WORD_LEN-1] acc_q, acc_d;
   logic [FW-1:0]              fill_q, fill_d, fill_after_pop, pop_cnt;
   packer_state_t              state_q, state_d;
   logic                       len_err_q, len_err_d;
   logic [LEN_W-1:0]           len;
   logic                       len_ill, in_fire, out_fire, pad_line;

   instr_len_decd u_decd (
      .len_code (bus.instr_in[0][0:IDX_LEN-1]),
      .len      (len),
      .len_ill  (len_ill)
   );

   assign pad_line = (state_q == FLUSH) && (fill_q < FW'(W));
   assign bus.packer_2_fifo_vld = (fill_q >= FW'(W)) || ((state_q == FLUSH) && (fill_q != '0));
   assign out_fire = bus.packer_2_fifo_vld & bus.fifo_2_packer_rdy;
   // A padded line retires only the real words, so fill never underflows.
   assign pop_cnt        = !out_fire ? '0 : (pad_line ? fill_q : FW'(W));
   assign fill_after_pop = fill_q - pop_cnt;
   assign bus.packer_2_src_rdy = (state_q == PACK) && (fill_after_pop <= FW'(W));
   assign in_fire        = bus.src_2_packer_vld & bus.packer_2_src_rdy;
   assign bus.flush_done = (state_q == DONE);
   assign bus.len_err    = len_err_q;

   instr_packer_merge #(
      .WORD_LEN (WORD_LEN),
      .W        (W),
      .M        (M),
      .T        (T),
      .FW       (FW)
   ) u_merge (
      .acc     (acc_q),
      .pop     (out_fire),
      .wr_en   (in_fire),
      .pos     (fill_after_pop),
      .len     (len),
      .words   (bus.instr_in),
      .acc_nxt (acc_d)
   );

   always_comb begin
      fill_d    = fill_after_pop + (in_fire ? FW'(len) : '0);
      len_err_d = len_err_q | (in_fire & len_ill);
      state_d   = state_q;
      case (state_q)
         PACK:    if (bus.flush) state_d = FLUSH;
         FLUSH:   if (fill_d == '0) state_d = DONE;
         DONE:    state_d = PACK;
         default: state_d = PACK;
      endcase
   end

   always_comb begin
      for (int i = 0; i < W; i++)
         bus.line_out[i] = (pad_line && FW'(i) >= fill_q) ? WORD_LEN'(PAD_WORD) : acc_q[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         fill_q    <= '0;
         state_q   <= PACK;
         len_err_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         fill_q    <= fill_d;
         state_q   <= state_d;
         len_err_q <= len_err_d;
      end
   end

`ifdef INSTR_PACKER_STATS_EN
   logic [31:0] n_instr_q, n_instr_d, n_lines_q, n_lines_d, n_pad_words_q, n_pad_words_d;

   always_comb begin
      n_instr_d     = n_instr_q;
      n_lines_d     = n_lines_q;
      n_pad_words_d = n_pad_words_q;
      if (in_fire)  n_instr_d = sat_add(n_instr_q, 32'd1);
      if (out_fire) n_lines_d = sat_add(n_lines_q, 32'd1);
      if (out_fire && pad_line)
         n_pad_words_d = sat_add(n_pad_words_q, 32'(FW'(W) - fill_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_instr_q     <= '0;
         n_lines_q     <= '0;
         n_pad_words_q <= '0;
      end else begin
         n_instr_q     <= n_instr_d;
         n_lines_q     <= n_lines_d;
         n_pad_words_q <= n_pad_words_d;
      end
   end

   assign n_instr     = n_instr_q;
   assign n_lines     = n_lines_q;
   assign n_pad_words = n_pad_words_q;
`endif

   a_fill_max: assert property (@(posedge clk) disable iff (rst) fill_q <= FW'(T));
   a_len_max:  assert property (@(posedge clk) disable iff (rst) in_fire |-> int'(len) <= M);
   a_m_le_w:   assert property (@(posedge clk) M <= W);

endmodule

// File: tb/tb_instr_packer.sv
// Randomized bench for instr_packer (W=4, lengths {1,2,4}) against a word-queue
// reference model of the packing, flush and length-error rules.
module tb_instr_packer;
   import instr_pkg::*;

   localparam int W  = 4;
   localparam int M  = 4;
   localparam int WL = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_packer_if #(.WORD_LEN(WL), .W(W), .M(M)) bus ();

`ifdef INSTR_PACKER_STATS_EN
   logic [31:0] n_instr, n_lines, n_pad_words;
`endif

   instr_packer #(.WORD_LEN(WL), .INSTR_FIFO_WIDTH(W), .MAX_INSTR_LEN(M)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef INSTR_PACKER_STATS_EN
      ,
      .n_instr     (n_instr),
      .n_lines     (n_lines),
      .n_pad_words (n_pad_words)
`endif
   );

   // Reference model: pending words in order, mode 0=pack 1=flush 2=done.
   logic [31:0] q[$];
   int          mode;
   bit          m_err;
   int          lens[3] = '{1, 2, 4};
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [W*WL-1:0] obs, input logic [W*WL-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic cycle(input bit v, input int code, input bit fl, input bit frdy);
      logic [31:0]           w [M];
      logic [0:W-1][0:WL-1]  exp_line;
      bit                    ev, er, ofire, ifire;
      int                    sz, pop, ln;
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < M; j++) w[j] = $urandom;
      w[0][31:30] = 2'(code);
      for (int j = 0; j < M; j++) bus.instr_in[j] = w[j];
      bus.src_2_packer_vld  = v;
      bus.flush             = fl;
      bus.fifo_2_packer_rdy = frdy;
      #1;
      sz = q.size();
      ev = (sz >= W) || (mode == 1 && sz > 0);
      chk("fifo_vld", bus.packer_2_fifo_vld, ev);
      if (ev) begin
         for (int i = 0; i < W; i++) exp_line[i] = (i < sz) ? q[i] : PAD_WORD;
         chk("line_out", bus.line_out, exp_line);
      end
      ofire = ev && frdy;
      pop   = ofire ? ((sz < W) ? sz : W) : 0;
      er    = (mode == 0) && (sz - pop <= W);
      chk("src_rdy", bus.packer_2_src_rdy, er);
      chk("flush_done", bus.flush_done, mode == 2);
      chk("len_err", bus.len_err, m_err);
      ifire = v && er;
      repeat (pop) void'(q.pop_front());
      if (ifire) begin
         ln = (code < 3) ? lens[code] : 1;
         if (code >= 3) m_err = 1'b1;
         for (int j = 0; j < ln; j++) q.push_back(w[j]);
      end
      case (mode)
         0: if (fl) mode = 1;
         1: if (q.size() == 0) mode = 2;
         default: mode = 0;
      endcase
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1'b1;
      bus.src_2_packer_vld  = 1'b0;
      bus.flush             = 1'b0;
      bus.fifo_2_packer_rdy = 1'b1;
      q.delete();
      mode  = 0;
      m_err = 1'b0;
   endtask

   initial begin
      bus.instr_in          = '0;
      bus.src_2_packer_vld  = 1'b0;
      bus.flush             = 1'b0;
      bus.fifo_2_packer_rdy = 1'b1;
      mode  = 0;
      m_err = 1'b0;
      do_rst();
      do_rst();
      cycle(0, 0, 0, 1);

      // four single-word instructions fill one line
      repeat (4) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);

      // 2 + 4 + 2 words: second instruction straddles two lines
      cycle(1, 1, 0, 1);
      cycle(1, 2, 0, 1);
      cycle(1, 1, 0, 1);
      repeat (3) cycle(0, 0, 0, 1);

      // three words then flush: padded line, then flush_done
      repeat (3) cycle(1, 0, 0, 1);
      cycle(0, 0, 1, 1);
      repeat (4) cycle(1, 0, 0, 1);

      // FIFO backpressure with a 4-word instruction pending
      repeat (4) cycle(1, 0, 0, 0);
      repeat (3) cycle(1, 2, 0, 0);
      repeat (3) cycle(1, 2, 0, 1);
      repeat (3) cycle(0, 0, 0, 1);

      // flush with nothing buffered
      cycle(0, 0, 1, 1);
      repeat (3) cycle(0, 0, 0, 1);

      // illegal length code is sticky until reset
      cycle(1, 3, 0, 1);
      repeat (3) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);

      // reset while flushing a 2-word partial line
      do_rst();
      repeat (2) cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
      do_rst();
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);

      // random traffic
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 99) == 0) do_rst();
         else cycle($urandom_range(0, 2) != 0,
                    ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2)),
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 3) != 0);
      end
      repeat (10) cycle(0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
